sha_256_sched: RTL and testbench

SHA_256_SCHED -- requirements
Module: sha_256_sched

---
 rtl/sha_256_pkg.sv | 11 +
 rtl/sha_256_sched_if.sv | 35 +++
 rtl/sha_256_sched_rr_arbiter.sv | 27 ++
 rtl/sha_256_sched.sv | 118 +++++++++++
 tb/tb_sha_256_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sha_256_pkg.sv
// Shared constants and FSM state type for the sha_256 request scheduler.
package sha_256_pkg;
  localparam int MSG_SIZ   = 512;
  localparam int HASH_SIZE = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_t;
endpackage

// File: rtl/sha_256_sched_if.sv
// Requester / core / response signal bundle for sha_256_sched.
// slave = scheduler side, master = requesters + core + response consumer.
interface sha_256_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int MSG_SIZ   = 512,
  parameter int HASH_SIZE = 256
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]              i_req;
  logic [NUM_REQ-1:0][MSG_SIZ-1:0] i_msg_bus;
  logic [NUM_REQ-1:0]              o_gnt;
  logic                            o_core_start;
  logic [MSG_SIZ-1:0]              o_core_msg;
  logic                            i_core_valid;
  logic [HASH_SIZE-1:0]            i_core_hash;
  logic                            o_rsp_valid;
  logic [IDW-1:0]                  o_rsp_id;
  logic [HASH_SIZE-1:0]            o_rsp_hash;
  logic                            o_rsp_err;
  logic                            i_rsp_ready;
  logic                            o_busy;

  modport slave (
    input  i_req, i_msg_bus, i_core_valid, i_core_hash, i_rsp_ready,
    output o_gnt, o_core_start, o_core_msg, o_rsp_valid, o_rsp_id,
           o_rsp_hash, o_rsp_err, o_busy
  );

  modport master (
    output i_req, i_msg_bus, i_core_valid, i_core_hash, i_rsp_ready,
    input  o_gnt, o_core_start, o_core_msg, o_rsp_valid, o_rsp_id,
           o_rsp_hash, o_rsp_err, o_busy
  );
endinterface

// File: rtl/sha_256_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. Output is one-hot, or zero when nothing is requested.
module rr_arbiter import sha_256_pkg::*; #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt
);
  logic           found;
  logic [IDW-1:0] idx;

  // scan N positions starting at ptr, keep the first hit
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sha_256_sched.sv
// Round-robin scheduler sharing one sha_256 core between NUM_REQ requesters.
// IDLE grants a winner and latches its block, RUN holds the core enabled until
// it returns a hash, RESP presents the result until the consumer accepts it.
// Optional feature: define SHA_SCHED_TIMEOUT_EN to abort RUN after TIMEOUT_CYC
// cycles with o_rsp_err=1; without it RUN waits indefinitely and err is tied 0.
module sha_256_sched import sha_256_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int MSG_SIZ     = sha_256_pkg::MSG_SIZ,
`ifdef SHA_SCHED_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 128,
`endif
  parameter int HASH_SIZE   = sha_256_pkg::HASH_SIZE
) (
  input  logic             usr_clk,
  input  logic             usr_reset,
  sha_256_sched_if.slave   bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state, state_nxt;
  logic [IDW-1:0]     ptr, win_id;
  logic [NUM_REQ-1:0] win_gnt;
  logic               grant_now;
  logic               tmo_hit;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req (bus.i_req),
    .ptr (ptr),
    .gnt (win_gnt)
  );

  assign grant_now = (state == IDLE) && (|bus.i_req);

  // one-hot winner to index
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_gnt[i]) win_id = IDW'(i);
  end

`ifdef SHA_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt;

  // RUN-cycle counter, cleared on the grant that enters RUN
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset)                 tmo_cnt <= '0;
    else if (grant_now)            tmo_cnt <= '0;
    else if (state == RUN)         tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == RUN) && !bus.i_core_valid &&
                   (tmo_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  // next-state logic; core_valid only matters in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|bus.i_req)                    state_nxt = RUN;
      RUN:     if (bus.i_core_valid || tmo_hit)   state_nxt = RESP;
      RESP:    if (bus.i_rsp_ready)               state_nxt = IDLE;
      default:                                    state_nxt = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    bus.o_core_start = (state == RUN);
    bus.o_rsp_valid  = (state == RESP);
    bus.o_busy       = (state != IDLE);
  end

  // grant pulse, latched block/id/hash and round-robin pointer
  always_ff @(posedge usr_clk or posedge usr_reset) begin
    if (usr_reset) begin
      bus.o_gnt      <= '0;
      bus.o_core_msg <= '0;
      bus.o_rsp_id   <= '0;
      bus.o_rsp_hash <= '0;
      ptr            <= '0;
`ifdef SHA_SCHED_TIMEOUT_EN
      bus.o_rsp_err  <= 1'b0;
`endif
    end else begin
      bus.o_gnt <= '0;
      if (grant_now) begin
        bus.o_gnt      <= win_gnt;
        bus.o_core_msg <= bus.i_msg_bus[win_id];
        bus.o_rsp_id   <= win_id;
        ptr            <= (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
      if (state == RUN && bus.i_core_valid) begin
        bus.o_rsp_hash <= bus.i_core_hash;
`ifdef SHA_SCHED_TIMEOUT_EN
        bus.o_rsp_err  <= 1'b0;
`endif
      end else if (tmo_hit) begin
        bus.o_rsp_hash <= '0;
`ifdef SHA_SCHED_TIMEOUT_EN
        bus.o_rsp_err  <= 1'b1;
`endif
      end
    end
  end

`ifndef SHA_SCHED_TIMEOUT_EN
  assign bus.o_rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_sha_256_sched.sv
// Directed bench for sha_256_sched: a table of grant/response transactions
// plus hand-written backpressure, timeout and mid-RUN reset sequences.
module tb_sha_256_sched;
  import sha_256_pkg::*;

  localparam int NR = 4;
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic usr_clk = 1'b0;
  logic usr_reset;
  always #5 usr_clk = ~usr_clk;

  sha_256_sched_if #(.NUM_REQ(NR), .MSG_SIZ(MSG_SIZ), .HASH_SIZE(HASH_SIZE)) bus ();

  sha_256_sched #(.NUM_REQ(NR), .MSG_SIZ(MSG_SIZ), .HASH_SIZE(HASH_SIZE)) dut (
    .usr_clk   (usr_clk),
    .usr_reset (usr_reset),
    .bus       (bus)
  );

  typedef struct {
    logic [3:0]   req;
    int           exp_id;
    logic [255:0] hash;
  } vec_t;

  int           checks   = 0;
  int           failures = 0;
  logic [511:0] blk [4];
  vec_t         tbl [9];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " o_gnt"},        512'(bus.o_gnt),        '0);
    chk({tag, " o_core_start"}, 512'(bus.o_core_start), '0);
    chk({tag, " o_core_msg"},   512'(bus.o_core_msg),   '0);
    chk({tag, " o_rsp_valid"},  512'(bus.o_rsp_valid),  '0);
    chk({tag, " o_rsp_id"},     512'(bus.o_rsp_id),     '0);
    chk({tag, " o_rsp_hash"},   512'(bus.o_rsp_hash),   '0);
    chk({tag, " o_rsp_err"},    512'(bus.o_rsp_err),    '0);
    chk({tag, " o_busy"},       512'(bus.o_busy),       '0);
  endtask

  // called at a negedge with the scheduler in IDLE; ends at the negedge
  // following response accept (scheduler back in IDLE)
  task automatic run_txn(input logic [3:0] req, input int exp_id,
                         input logic [255:0] hash, input string tag);
    int w;
    w = 0;
    bus.i_req = req;
    do begin
      @(negedge usr_clk);
      w++;
    end while (bus.o_gnt == '0 && w < 20);
    chk({tag, " grant latency"}, 512'(w), 512'(1));
    chk({tag, " o_gnt"},        512'(bus.o_gnt), 512'(4'(1) << exp_id));
    chk({tag, " o_core_msg"},   bus.o_core_msg, blk[exp_id[1:0]]);
    chk({tag, " o_core_start"}, 512'(bus.o_core_start), 512'(1));
    chk({tag, " o_busy"},       512'(bus.o_busy), 512'(1));
    @(negedge usr_clk);
    chk({tag, " o_gnt pulse"},  512'(bus.o_gnt), '0);
    @(negedge usr_clk);
    bus.i_core_hash  = hash;
    bus.i_core_valid = 1'b1;
    @(negedge usr_clk);
    bus.i_core_valid = 1'b0;
    bus.i_core_hash  = '0;
    chk({tag, " o_rsp_valid"},  512'(bus.o_rsp_valid), 512'(1));
    chk({tag, " o_rsp_id"},     512'(bus.o_rsp_id), 512'(exp_id));
    chk({tag, " o_rsp_hash"},   512'(bus.o_rsp_hash), 512'(hash));
    chk({tag, " o_rsp_err"},    512'(bus.o_rsp_err), '0);
    chk({tag, " start in RESP"}, 512'(bus.o_core_start), '0);
    bus.i_rsp_ready = 1'b1;
    @(negedge usr_clk);
    bus.i_rsp_ready = 1'b0;
    chk({tag, " valid after accept"}, 512'(bus.o_rsp_valid), '0);
    chk({tag, " busy after accept"},  512'(bus.o_busy), '0);
  endtask

  // drive core + accept for a transaction that is already in RUN
  task automatic finish_txn(input logic [255:0] hash, input int exp_id, input string tag);
    bus.i_core_hash  = hash;
    bus.i_core_valid = 1'b1;
    @(negedge usr_clk);
    bus.i_core_valid = 1'b0;
    chk({tag, " o_rsp_id"},   512'(bus.o_rsp_id), 512'(exp_id));
    chk({tag, " o_rsp_hash"}, 512'(bus.o_rsp_hash), 512'(hash));
    bus.i_rsp_ready = 1'b1;
    @(negedge usr_clk);
    bus.i_rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [255:0] hb;

    blk[0] = {32'h61626380, 416'h0, 64'h18};
    for (int k = 1; k < 4; k++) blk[k] = {16{32'hB10C0000 + 32'(k)}};

    // ptr 0 after reset: all four held -> 0,1,2,3
    tbl[0] = '{4'b1111, 0, {8{32'hC0DE0000}}};
    tbl[1] = '{4'b1110, 1, {8{32'hC0DE0001}}};
    tbl[2] = '{4'b1100, 2, {8{32'hC0DE0002}}};
    tbl[3] = '{4'b1000, 3, {8{32'hC0DE0003}}};
    // ptr wrapped to 0: single "abc" block
    tbl[4] = '{4'b0001, 0, ABC_HASH};
    // ptr 1, req0 and req2 held -> 2,0,2,0
    tbl[5] = '{4'b0101, 2, {8{32'hC0DE0005}}};
    tbl[6] = '{4'b0101, 0, {8{32'hC0DE0006}}};
    tbl[7] = '{4'b0101, 2, {8{32'hC0DE0007}}};
    tbl[8] = '{4'b0101, 0, {8{32'hC0DE0008}}};

    usr_reset        = 1'b1;
    bus.i_req        = '0;
    bus.i_msg_bus    = {blk[3], blk[2], blk[1], blk[0]};
    bus.i_core_valid = 1'b0;
    bus.i_core_hash  = '0;
    bus.i_rsp_ready  = 1'b0;
    repeat (2) @(negedge usr_clk);
    chk_zero("reset");
    usr_reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_txn(tbl[i].req, tbl[i].exp_id, tbl[i].hash, $sformatf("vec%0d", i));
    bus.i_req = '0;

    // backpressure: ptr 1, req1 -> grant 1; response held 10 cycles with
    // other requests pending and a stray core_valid that must be ignored
    hb = {8{32'hBAC0FFEE}};
    bus.i_req = 4'b0010;
    @(negedge usr_clk);
    chk("bp o_gnt", 512'(bus.o_gnt), 512'(4'b0010));
    bus.i_req = 4'b1111;
    repeat (2) @(negedge usr_clk);
    bus.i_core_hash  = hb;
    bus.i_core_valid = 1'b1;
    @(negedge usr_clk);
    bus.i_core_hash  = {8{32'hDEADBEEF}};
    for (int c = 0; c < 10; c++) begin
      @(negedge usr_clk);
      chk("bp o_rsp_valid", 512'(bus.o_rsp_valid), 512'(1));
      chk("bp o_rsp_id",    512'(bus.o_rsp_id), 512'(1));
      chk("bp o_rsp_hash",  512'(bus.o_rsp_hash), 512'(hb));
      chk("bp o_gnt",       512'(bus.o_gnt), '0);
    end
    bus.i_core_valid = 1'b0;
    bus.i_rsp_ready  = 1'b1;
    @(negedge usr_clk);
    bus.i_rsp_ready  = 1'b0;
    chk("bp accept gnt", 512'(bus.o_gnt), '0);
    @(negedge usr_clk);
    chk("bp next grant", 512'(bus.o_gnt), 512'(4'b0100));
    bus.i_req = '0;
    @(negedge usr_clk);
    finish_txn({8{32'h22222222}}, 2, "bp follow");

    // timeout: ptr 3, req0 -> grant 0, core never answers
    bus.i_req = 4'b0001;
    @(negedge usr_clk);
    chk("tmo o_gnt", 512'(bus.o_gnt), 512'(4'b0001));
    bus.i_req = '0;
    n = 0;
    while (bus.o_core_start && n < 1000) begin
      n++;
      @(negedge usr_clk);
    end
`ifdef SHA_SCHED_TIMEOUT_EN
    chk("tmo run cycles",  512'(n), 512'(128));
    chk("tmo o_rsp_valid", 512'(bus.o_rsp_valid), 512'(1));
    chk("tmo o_rsp_err",   512'(bus.o_rsp_err), 512'(1));
    chk("tmo o_rsp_hash",  512'(bus.o_rsp_hash), '0);
    chk("tmo o_rsp_id",    512'(bus.o_rsp_id), '0);
    bus.i_rsp_ready = 1'b1;
    @(negedge usr_clk);
    bus.i_rsp_ready = 1'b0;
    chk("tmo accept busy", 512'(bus.o_busy), '0);
`else
    chk("no-tmo run cycles",   512'(n), 512'(1000));
    chk("no-tmo o_core_start", 512'(bus.o_core_start), 512'(1));
    chk("no-tmo o_rsp_valid",  512'(bus.o_rsp_valid), '0);
    usr_reset = 1'b1;
    #1;
    chk_zero("no-tmo reset");
    @(negedge usr_clk);
    usr_reset = 1'b0;
`endif

    // reset 30 cycles into RUN, then pointer must restart at 0
    bus.i_req = 4'b0010;
    @(negedge usr_clk);
    chk("rst o_gnt", 512'(bus.o_gnt), 512'(4'b0010));
    bus.i_req = '0;
    repeat (29) @(negedge usr_clk);
    chk("rst pre start", 512'(bus.o_core_start), 512'(1));
    usr_reset = 1'b1;
    #1;
    chk_zero("mid-run reset");
    @(negedge usr_clk);
    usr_reset = 1'b0;
    run_txn(4'b0101, 0, {8{32'h0A0A0A0A}}, "post-reset ptr");
    run_txn(4'b0100, 2, {8{32'h0B0B0B0B}}, "post-reset req2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
